// File: rtl/cpu_pkg.sv
// Shared CPU execute-stage definitions: divider FSM states, iteration count
// and the RV32M divide-by-zero quotient.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } divide_state_t;

    localparam int DIVIDE_ITERATIONS = 32;

    localparam logic [31:0] DIVIDE_BY_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    // Two's-complement magnitude of a value whose sign has already been decided.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic negative);
        return negative ? -value : value;
    endfunction

endpackage

// File: rtl/cpu_divide_if.sv
// Latch/ready handshake shared by the execute-stage multiplier and divider.
interface cpu_divide_if;

    logic        i_latch;
    logic        i_signed;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        o_ready;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    modport master (
        output i_latch, i_signed, i_op1, i_op2,
        input  o_ready, o_quotient, o_remainder
    );

    modport slave (
        input  i_latch, i_signed, i_op1, i_op2,
        output o_ready, o_quotient, o_remainder
    );

endinterface

// File: rtl/cpu_divide_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module cpu_divide_step (
    input  logic [32:0] rem,
    input  logic [31:0] q,
    input  logic [31:0] divisor,
    output logic [32:0] rem_next,
    output logic [31:0] q_next
);

    logic [33:0] trial;
    logic [32:0] difference;
    logic        fits;

    always_comb begin
        trial      = {rem, q[31]};
        fits       = trial >= {2'b00, divisor};
        difference = trial[32:0] - {1'b0, divisor};
        rem_next   = fits ? difference : trial[32:0];
        q_next     = {q[30:0], fits};
    end

endmodule

// File: rtl/cpu_divide.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU), one restoring step per clock.
// Optional macro CPU_DIVIDE_EARLY_OUT_EN skips the iterations when the answer is trivial.
module cpu_divide (
    input logic         i_clock,
    input logic         i_reset,
    cpu_divide_if.slave bus
);

    import cpu_pkg::*;

    localparam logic [5:0] LAST_STEP = 6'(DIVIDE_ITERATIONS - 1);

    divide_state_t state;
    divide_state_t state_next;

    logic        latch_q;
    logic [5:0]  count;
    logic [32:0] rem;
    logic [31:0] q;
    logic [31:0] divisor;
    logic [31:0] dividend;
    logic        zero;
    logic        dividend_sign;
    logic        quot_neg;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    logic        start;
    logic        sign1;
    logic        sign2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        early;
    logic [32:0] rem_step;
    logic [31:0] q_step;
    logic [31:0] fix_quotient;
    logic [31:0] fix_remainder;

    cpu_divide_step step (
        .rem      (rem),
        .q        (q),
        .divisor  (divisor),
        .rem_next (rem_step),
        .q_next   (q_step)
    );

    always_comb begin
        start = bus.i_latch && !latch_q && (state == IDLE);
        sign1 = bus.i_signed & bus.i_op1[31];
        sign2 = bus.i_signed & bus.i_op2[31];
        mag1  = magnitude(bus.i_op1, sign1);
        mag2  = magnitude(bus.i_op2, sign2);
`ifdef CPU_DIVIDE_EARLY_OUT_EN
        early = (bus.i_op2 == 32'd0) || (mag1 < mag2);
`else
        early = 1'b0;
`endif
    end

    // Divide-by-zero keeps the untouched dividend as the remainder, as RV32M requires.
    always_comb begin
        fix_quotient  = zero ? DIVIDE_BY_ZERO_QUOTIENT : (quot_neg ? -q : q);
        fix_remainder = zero ? dividend : (dividend_sign ? -rem[31:0] : rem[31:0]);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = early ? FIX : DIV;
            DIV:     if (count == LAST_STEP) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            latch_q <= 1'b0;
        end else begin
            state   <= state_next;
            latch_q <= bus.i_latch;
        end
    end

    // An early-out leaves the dividend magnitude in rem with q=0, so FIX needs no extra case.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count         <= '0;
            rem           <= '0;
            q             <= '0;
            divisor       <= '0;
            dividend      <= '0;
            zero          <= 1'b0;
            dividend_sign <= 1'b0;
            quot_neg      <= 1'b0;
            ready         <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        divisor       <= mag2;
                        dividend      <= bus.i_op1;
                        zero          <= (bus.i_op2 == 32'd0);
                        dividend_sign <= sign1;
                        quot_neg      <= sign1 ^ sign2;
                        count         <= '0;
                        if (early) begin
                            rem <= {1'b0, mag1};
                            q   <= '0;
                        end else begin
                            rem <= '0;
                            q   <= mag1;
                        end
                    end
                end
                DIV: begin
                    rem   <= rem_step;
                    q     <= q_step;
                    count <= count + 6'd1;
                end
                FIX: begin
                    quotient  <= fix_quotient;
                    remainder <= fix_remainder;
                    ready     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_quotient  = quotient;
    assign bus.o_remainder = remainder;

endmodule

// File: tb/tb_cpu_divide.sv
// Self-checking bench for cpu_divide: table of RV32M divide vectors, random
// operands against a behavioural model, and handshake/reset corner sequences.
module tb_cpu_divide;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] quot;
        logic [31:0] rem;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] quot;
        logic [31:0] rem;
        int          latency;
        int          start_cycle;
    } exp_t;

    logic clock;
    logic reset;
    int   cycle_count;
    int   check_count;
    int   pass_count;
    int   ready_count;
    bit   check_drop;
    exp_t sb[$];
    vec_t vecs[$];

    cpu_divide_if bus ();

    cpu_divide dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic int expLatency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef CPU_DIVIDE_EARLY_OUT_EN
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        return (b == 32'd0 || ma < mb) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // Reference RV32M semantics straight from the language's truncating division.
    task automatic refDivide(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] qo, output logic [31:0] ro);
        if (b == 32'd0) begin
            qo = 32'hFFFF_FFFF;
            ro = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            qo = 32'h8000_0000;
            ro = 32'd0;
        end else if (sgn) begin
            qo = $signed(a) / $signed(b);
            ro = $signed(a) % $signed(b);
        end else begin
            qo = a / b;
            ro = a % b;
        end
    endtask

    // Completion monitor: pops the scoreboard on every ready pulse.
    always @(negedge clock) begin
        exp_t e;
        if (check_drop) begin
            checkOutput("ready_one_cycle", 32'(bus.o_ready), 32'd0);
            check_drop = 1'b0;
        end
        if (bus.o_ready === 1'b1) begin
            ready_count++;
            check_drop = 1'b1;
            if (sb.size() == 0) begin
                checkOutput("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_quotient"}, bus.o_quotient, e.quot);
                checkOutput({e.name, "_remainder"}, bus.o_remainder, e.rem);
                checkOutput({e.name, "_latency"}, 32'(cycle_count - e.start_cycle), 32'(e.latency));
            end
        end
    end

    task automatic pushExpected(input string name, input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] qx, input logic [31:0] rx);
        exp_t e;
        e.name        = name;
        e.quot        = qx;
        e.rem         = rx;
        e.latency     = expLatency(sgn, a, b);
        e.start_cycle = cycle_count;
        sb.push_back(e);
    endtask

    task automatic waitIdle(input string name);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        checkOutput({name, "_done"}, 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] qx, input logic [31:0] rx);
        @(negedge clock);
        bus.i_signed = sgn;
        bus.i_op1    = a;
        bus.i_op2    = b;
        bus.i_latch  = 1'b1;
        @(posedge clock);
        #1;
        pushExpected(name, sgn, a, b, qx, rx);
        @(negedge clock);
        bus.i_latch  = 1'b0;
        bus.i_signed = ~sgn;
        bus.i_op1    = $urandom;
        bus.i_op2    = $urandom;
        waitIdle(name);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] qx;
        logic [31:0] rx;
        logic        sgn;
        int          rc;
        int          sc;

        check_count  = 0;
        pass_count   = 0;
        ready_count  = 0;
        check_drop   = 1'b0;
        cycle_count  = 0;
        reset        = 1'b1;
        bus.i_latch  = 1'b0;
        bus.i_signed = 1'b0;
        bus.i_op1    = '0;
        bus.i_op2    = '0;

        vecs.push_back('{"udiv_100_7",      1'b0, 32'd100,       32'd7,         32'd14,        32'd2});
        vecs.push_back('{"sdiv_m100_7",     1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE});
        vecs.push_back('{"sdiv_100_m7",     1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2});
        vecs.push_back('{"sdiv_m100_m7",    1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE});
        vecs.push_back('{"sdiv_by_zero",    1'b1, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678});
        vecs.push_back('{"udiv_by_zero",    1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678});
        vecs.push_back('{"sdiv_min_by_zero",1'b1, 32'h80000000,  32'd0,         32'hFFFFFFFF,  32'h80000000});
        vecs.push_back('{"sdiv_overflow",   1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0});
        vecs.push_back('{"udiv_min_max",    1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000});
        vecs.push_back('{"udiv_max_1",      1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0});
        vecs.push_back('{"udiv_max_max",    1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0});
        vecs.push_back('{"udiv_3_9",        1'b0, 32'd3,         32'd9,         32'd0,         32'd3});
        vecs.push_back('{"sdiv_m3_9",       1'b1, 32'hFFFFFFFD,  32'd9,         32'd0,         32'hFFFFFFFD});

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_ready", 32'(bus.o_ready), 32'd0);
        checkOutput("reset_quotient", bus.o_quotient, 32'd0);
        checkOutput("reset_remainder", bus.o_remainder, 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].name, vecs[i].sgn, vecs[i].op1, vecs[i].op2, vecs[i].quot, vecs[i].rem);

        for (int i = 0; i < 8; i++) begin
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            sgn = 1'($urandom_range(0, 1));
            refDivide(sgn, a, b, qx, rx);
            applyStimulus($sformatf("rand%0d", i), sgn, a, b, qx, rx);
        end

        $display("[TB] latch held high across completion");
        rc = ready_count;
        @(negedge clock);
        bus.i_signed = 1'b0;
        bus.i_op1    = 32'd1000;
        bus.i_op2    = 32'd10;
        bus.i_latch  = 1'b1;
        @(posedge clock);
        #1;
        pushExpected("held_latch", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
        repeat (45) @(negedge clock);
        checkOutput("held_latch_ready_count", 32'(ready_count - rc), 32'd1);
        sb.delete();
        bus.i_latch = 1'b0;
        applyStimulus("after_held_latch", 1'b0, 32'd77, 32'd7, 32'd11, 32'd0);
        checkOutput("after_held_ready_count", 32'(ready_count - rc), 32'd2);

        $display("[TB] latch pulsed during iteration");
        rc = ready_count;
        @(negedge clock);
        bus.i_signed = 1'b0;
        bus.i_op1    = 32'd200;
        bus.i_op2    = 32'd9;
        bus.i_latch  = 1'b1;
        @(posedge clock);
        #1;
        pushExpected("pulse_in_div", 1'b0, 32'd200, 32'd9, 32'd22, 32'd2);
        @(negedge clock);
        bus.i_latch = 1'b0;
        repeat (4) @(negedge clock);
        bus.i_latch = 1'b1;
        @(negedge clock);
        bus.i_latch = 1'b0;
        waitIdle("pulse_in_div");
        repeat (40) @(negedge clock);
        checkOutput("pulse_in_div_ready_count", 32'(ready_count - rc), 32'd1);

        $display("[TB] reset during iteration");
        rc = ready_count;
        @(negedge clock);
        bus.i_signed = 1'b0;
        bus.i_op1    = 32'h12345678;
        bus.i_op2    = 32'd3;
        bus.i_latch  = 1'b1;
        @(posedge clock);
        #1;
        sc = cycle_count;
        @(negedge clock);
        bus.i_latch = 1'b0;
        while (cycle_count < sc + 9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid_reset_ready", 32'(bus.o_ready), 32'd0);
        checkOutput("mid_reset_quotient", bus.o_quotient, 32'd0);
        checkOutput("mid_reset_remainder", bus.o_remainder, 32'd0);
        repeat (40) @(negedge clock);
        checkOutput("mid_reset_no_ready", 32'(ready_count - rc), 32'd0);
        applyStimulus("after_reset_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cpu_divide.md
# cpu_divide

Iterative 32-bit integer divider for the CPU execute stage, the inverse counterpart to the pipelined multiplier. It produces quotient and remainder for RV32M DIV/DIVU/REM/REMU with one restoring step per clock. It uses the same latch/ready handshake as the multiplier, so the execute stage can drive both units identically.

## Interface
- No parameters. Width is fixed at 32; the iteration count comes from the package.
- i_clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_latch  input  1  request level; a rising edge starts a division.
- i_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled at start.
- i_op1  input  32  dividend; sampled at start.
- i_op2  input  32  divisor; sampled at start.
- o_ready  output  1  one-cycle pulse when o_quotient/o_remainder are valid.
- o_quotient  output  32  quotient; holds until the next completion.
- o_remainder  output  32  remainder; holds until the next completion.

## Operation
- Start detection:
  - Register latch_q <= i_latch every cycle, including while busy.
  - A start is accepted when i_latch=1, latch_q=0 and state=IDLE.
  - A rising edge while not IDLE is ignored, not queued.
- States: IDLE, DIV, FIX.
- IDLE, on start:
  - Capture the operand signs: s1=i_op1[31] and s2=i_op2[31] when i_signed, else 0.
  - Capture the magnitudes: |op1| and |op2|, two's-complement negated when the sign is set.
  - Capture flags: zero = (i_op2==0), dividend_sign = s1, quot_neg = s1^s2.
  - Clear the 33-bit partial remainder; load the dividend magnitude into the quotient shift register; count=0.
  - Go to DIV.
- DIV, one restoring step per cycle:
  - t = {rem[31:0], q[31]}; q <= {q[30:0], t>=divisor}; rem <= (t>=divisor) ? t-divisor : t.
  - count increments each step; after the 32nd step go to FIX.
- FIX:
  - zero=1: o_quotient=32'hFFFFFFFF and o_remainder=original i_op1, for both signed and unsigned.
  - Otherwise: o_quotient = quot_neg ? -q : q, and o_remainder = dividend_sign ? -rem : rem.
  - Signed overflow (32'h80000000 / 32'hFFFFFFFF) falls out naturally: quotient 32'h80000000, remainder 0. No special path is needed.
  - Set o_ready=1 and go to IDLE.
- o_ready is cleared on every cycle not in FIX; it is never high for two consecutive cycles.

## Timing
- Reset values: state=IDLE, latch_q=0, o_ready=0, o_quotient=0, o_remainder=0, count=0.
- Start sampled at edge E0. Steps occur at E1..E32. Results and o_ready are registered at E33 and visible during the cycle after E33. o_ready drops at E34.
- Latency is 33 clocks from start to o_ready, independent of operand values (unless early-out is enabled, see Configuration).
- Back-to-back: a new rising edge sampled at E34 or later is accepted.
  - An edge that occurs during DIV/FIX and is still high afterwards has latch_q=1, so it does not start; the requester must drop i_latch first.
- Reset mid-operation (any state): return to IDLE on that edge, with no o_ready pulse and outputs cleared to 0.
- Operand changes after E0 have no effect.

## Configuration
- Macro: CPU_DIVIDE_EARLY_OUT_EN.
- Defined: IDLE checks at start for divisor==0, or |op1| < |op2|. When true, skip DIV and go to FIX.
  - FIX produces the special-case result, or quotient 0 with remainder = i_op1.
  - o_ready is visible after E1 (latency 1).
- Undefined: every operation takes the full 33-cycle path. The results are bit-identical in both builds.

## Structure
- Shared package cpu_pkg holds:
  - typedef enum divide_state_t {IDLE, DIV, FIX};
  - localparam DIVIDE_ITERATIONS = 32;
  - the constant DIVIDE_BY_ZERO_QUOTIENT = 32'hFFFFFFFF.
- One sub-module, cpu_divide_step: a combinational single restoring step.
  - Inputs: rem[32:0], q[31:0], divisor[31:0].
  - Outputs: next rem, next q.
  - Instantiated once in cpu_divide.

## Test plan
- Unsigned 100/7, i_signed=0 -> quotient 14, remainder 2, o_ready exactly one cycle, 33 clocks after start.
- Signed -100/7 (32'hFFFFFF9C / 7) -> quotient 32'hFFFFFFF2 (-14), remainder 32'hFFFFFFFE (-2). Also 100/-7 -> quotient -14, remainder 2.
- Divide by zero, 32'h12345678/0, both signed and unsigned -> quotient 32'hFFFFFFFF, remainder 32'h12345678.
- Signed overflow 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0.
- Hold i_latch high across completion, and pulse it during DIV -> exactly one o_ready; a new start is accepted only after i_latch returns low then high.
- Assert i_reset at E10 of a division -> no o_ready, outputs 0. Then 50/5 -> quotient 10, remainder 0. With CPU_DIVIDE_EARLY_OUT_EN, 3/9 -> quotient 0, remainder 3, o_ready 1 clock after start.
